// File: rtl/flush_redirect_ctrl_if.sv
// Bundle of the WB/CP0 commit events, IF fetch handshakes and the recovery
// outputs exchanged with flush_redirect_ctrl.
interface flush_redirect_ctrl_if;
  logic        ex_en;
  logic        eret_flush;
  logic        tlb_refetch;
  logic        tlb_refill;
  logic [31:0] ws_pc;
  logic [31:0] c0_epc;
  logic        if_req_fire;
  logic        if_resp_fire;
  logic        redirect_ready;
  logic        flush;
  logic        fetch_stall;
  logic        discard_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output ex_en, eret_flush, tlb_refetch, tlb_refill, ws_pc, c0_epc,
           if_req_fire, if_resp_fire, redirect_ready,
    input  flush, fetch_stall, discard_resp, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  ex_en, eret_flush, tlb_refetch, tlb_refill, ws_pc, c0_epc,
           if_req_fire, if_resp_fire, redirect_ready,
    output flush, fetch_stall, discard_resp, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/flush_redirect_ctrl.sv
// Pipeline recovery sequencer: captures the redirect target on a WB commit
// event, flushes, drains in-flight fetches, then hands the new PC to IF.
module flush_redirect_ctrl #(
  parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VEC = 32'hBFC0_0200,
  parameter int unsigned OUTST_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  flush_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [OUTST_W-1:0] cnt, cnt_next;
  logic [31:0]        pc_q, pc_next;
  logic               event_any;

  // Saturating outstanding-fetch counter; runs in every state.
  always_comb begin
    cnt_next = cnt;
    if (bus.if_req_fire && !bus.if_resp_fire && (cnt != '1))
      cnt_next = cnt + 1'b1;
    else if (bus.if_resp_fire && !bus.if_req_fire && (cnt != '0))
      cnt_next = cnt - 1'b1;
  end

  assign event_any = bus.ex_en || bus.eret_flush || bus.tlb_refetch;

  always_comb begin
    state_next         = state;
    pc_next            = pc_q;
    bus.flush          = 1'b0;
    bus.fetch_stall    = 1'b0;
    bus.discard_resp   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.busy           = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (event_any) begin
          state_next = FLUSH;
          if (bus.ex_en)
            pc_next = bus.tlb_refill ? REFILL_VEC : EXC_VEC;
          else if (bus.eret_flush)
            pc_next = bus.c0_epc;
          else
            pc_next = bus.ws_pc + 32'd4;
        end
      end
      FLUSH: begin
        bus.flush        = 1'b1;
        bus.fetch_stall  = 1'b1;
        bus.discard_resp = 1'b1;
        state_next       = (cnt_next != '0) ? DRAIN : REDIRECT;
      end
      DRAIN: begin
        bus.fetch_stall  = 1'b1;
        bus.discard_resp = 1'b1;
        if (cnt_next == '0)
          state_next = REDIRECT;
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.fetch_stall    = 1'b1;
        if (bus.redirect_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pc_q  <= pc_next;
    end
  end

  assign bus.redirect_pc = pc_q;

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed table-driven bench for flush_redirect_ctrl plus a hand-written
// asynchronous-reset-during-drain sequence.
module tb_flush_redirect_ctrl;
  logic clk;
  logic reset;
  flush_redirect_ctrl_if bus ();

  flush_redirect_ctrl #(
    .EXC_VEC   (32'hBFC0_0380),
    .REFILL_VEC(32'hBFC0_0200),
    .OUTST_W   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] EV = 32'hBFC0_0380;
  localparam logic [31:0] RV = 32'hBFC0_0200;
  // {flush, fetch_stall, discard_resp, redirect_valid, busy}
  localparam logic [4:0] O_ID = 5'b00000;
  localparam logic [4:0] O_FL = 5'b11101;
  localparam logic [4:0] O_DR = 5'b01101;
  localparam logic [4:0] O_RD = 5'b01011;

  typedef struct {
    logic        ex, eret, refetch, refill;
    logic [31:0] ws_pc, epc;
    logic        req, resp, ready;
    logic [4:0]  exp;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // The controller ignores events while busy; the stimulus must never produce one.
  always @(posedge clk)
    if (!reset)
      assert (!(bus.busy && (bus.ex_en || bus.eret_flush || bus.tlb_refetch)))
        else $error("commit event driven while controller busy");

  task automatic add(input logic ex, eret, refetch, refill,
                     input logic [31:0] ws_pc, epc,
                     input logic req, resp, ready,
                     input logic [4:0] exp, input logic chk_pc,
                     input logic [31:0] exp_pc);
    vec_t v;
    v.ex = ex; v.eret = eret; v.refetch = refetch; v.refill = refill;
    v.ws_pc = ws_pc; v.epc = epc; v.req = req; v.resp = resp; v.ready = ready;
    v.exp = exp; v.chk_pc = chk_pc; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.flush, bus.fetch_stall, bus.discard_resp, bus.redirect_valid, bus.busy};
  endfunction

  task automatic drive(input vec_t v);
    bus.ex_en = v.ex; bus.eret_flush = v.eret; bus.tlb_refetch = v.refetch;
    bus.tlb_refill = v.refill; bus.ws_pc = v.ws_pc; bus.c0_epc = v.epc;
    bus.if_req_fire = v.req; bus.if_resp_fire = v.resp; bus.redirect_ready = v.ready;
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, ".outs"}, {27'd0, outs()}, {27'd0, v.exp});
    if (v.chk_pc) chk({tag, ".pc"}, bus.redirect_pc, v.exp_pc);
  endtask

  function automatic vec_t nop(input logic [4:0] exp, input logic chk_pc, input logic [31:0] pc);
    vec_t v;
    v.ex = 0; v.eret = 0; v.refetch = 0; v.refill = 0; v.ws_pc = '0; v.epc = '0;
    v.req = 0; v.resp = 0; v.ready = 0; v.exp = exp; v.chk_pc = chk_pc; v.exp_pc = pc;
    return v;
  endfunction

  initial begin
    vec_t v;
    // ex ev rf rl ws_pc         epc           rq rs rdy exp   chk pc
    // 1: plain exception, no fetches outstanding
    add(1, 0, 0, 0, '0,           '0,           0, 0, 0, O_FL, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 0, O_RD, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // 2: two fetches in flight, TLB refill exception drains them
    add(0, 0, 0, 0, '0,           '0,           1, 0, 0, O_ID, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           1, 0, 0, O_ID, 0, '0);
    add(1, 0, 0, 1, '0,           '0,           0, 0, 0, O_FL, 1, RV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_RD, 1, RV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // 3: ERET with redirect_ready held low for 5 cycles
    add(0, 1, 0, 0, '0,           32'h8000_1234, 0, 0, 0, O_FL, 1, 32'h8000_1234);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, '0,         32'h5555_5555, 0, 0, 0, O_RD, 1, 32'h8000_1234);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // 4: refetch wraps past 2^32; ready during FLUSH has no effect
    add(0, 0, 1, 0, 32'hFFFF_FFFC, '0,          0, 0, 1, O_FL, 1, 32'h0000_0000);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_RD, 1, 32'h0000_0000);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // 5: ex_en beats eret_flush; eret_flush beats tlb_refetch
    add(1, 1, 0, 0, '0,           32'h8000_0000, 0, 0, 0, O_FL, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 0, O_RD, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    add(0, 1, 1, 0, 32'h0000_1000, 32'h1234_5678, 0, 0, 0, O_FL, 1, 32'h1234_5678);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_RD, 1, 32'h1234_5678);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // request accepted during FLUSH still has to drain
    add(1, 0, 0, 0, '0,           '0,           0, 0, 0, O_FL, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           1, 0, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_RD, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // counter saturates at 3: fourth request ignored, three responses drain
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, '0,         '0,           1, 0, 0, O_ID, 0, '0);
    add(1, 0, 0, 1, '0,           '0,           0, 0, 0, O_FL, 1, RV);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           1, 1, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_RD, 1, RV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);
    // response with cnt=0 must not underflow
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_ID, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           1, 0, 0, O_ID, 0, '0);
    add(1, 0, 0, 0, '0,           '0,           0, 0, 0, O_FL, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 0, O_DR, 0, '0);
    add(0, 0, 0, 0, '0,           '0,           0, 1, 0, O_RD, 1, EV);
    add(0, 0, 0, 0, '0,           '0,           0, 0, 1, O_ID, 0, '0);

    reset = 1'b1;
    drive(nop(O_ID, 0, '0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {27'd0, outs()}, {27'd0, O_ID});
    chk("reset.pc", bus.redirect_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // 6: async reset while draining one outstanding fetch
    v = nop(O_ID, 0, '0); v.req = 1;
    step(v, "r6.req");
    v = nop(O_FL, 1, EV); v.ex = 1;
    step(v, "r6.ex");
    step(nop(O_DR, 0, '0), "r6.drain");
    #2 reset = 1'b1;
    #1;
    chk("r6.async_outs", {27'd0, outs()}, {27'd0, O_ID});
    chk("r6.async_pc", bus.redirect_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    v = nop(O_FL, 1, RV); v.ex = 1; v.refill = 1;
    step(v, "r6.ex2");
    step(nop(O_RD, 1, RV), "r6.redir");
    v = nop(O_ID, 0, '0); v.ready = 1;
    step(v, "r6.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
